// File: rtl/comparatore_3bit_feeder.sv
// rtl/comparatore_3bit_feeder.sv - operand feeder for comparatore_3bit: assembles a/b/c, holds, samples cmp_out.
// Optional hit/total statistics enabled by COMPARATORE_FEEDER_STATS_EN.
module comparatore_3bit_feeder #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic             cmp_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] tot_count
);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_C, HOLD, REPORT} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             res_valid_q, res_valid_d, res_data_q, res_data_d;
  logic [7:0]       hold_q, hold_d;
  logic             accept, res_fire;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
  assign accept   = in_valid & in_ready;
  assign res_fire = res_valid_q & res_ready;

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    hold_d      = hold_q;
    case (state_q)
      LOAD_A: if (accept) begin sh_a_d = in_data; state_d = LOAD_B; end
      LOAD_B: if (accept) begin sh_b_d = in_data; state_d = LOAD_C; end
      // Whole triple lands on one edge so the comparator never sees a mix.
      LOAD_C: if (accept) begin
        a_d     = sh_a_q;
        b_d     = sh_b_q;
        c_d     = in_data;
        hold_d  = HOLD_INIT;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == 8'd0) begin
          res_data_d  = cmp_out;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      REPORT: if (res_fire) begin res_valid_d = 1'b0; state_d = LOAD_A; end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 1'b0;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      hold_q      <= hold_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

`ifdef COMPARATORE_FEEDER_STATS_EN
  logic [CNT_W-1:0] hit_q, hit_d, tot_q, tot_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_d = hit_q;
    tot_d = tot_q;
    if (res_fire) begin
      if (tot_q != {CNT_W{1'b1}}) tot_d = tot_q + CNT_W'(1);
      if (res_data_q && (hit_q != {CNT_W{1'b1}})) hit_d = hit_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
      tot_q <= '0;
    end else begin
      hit_q <= hit_d;
      tot_q <= tot_d;
    end
  end

  assign hit_count = hit_q;
  assign tot_count = tot_q;
`else
  assign hit_count = '0;
  assign tot_count = '0;
`endif

endmodule
